// File: rtl/change_dispenser_ctrl_pkg.sv
// Shared definitions for the change dispenser: coin values, hopper
// indices and the payout state encoding (also shown on the vending
// FSM's status display).
package change_dispenser_ctrl_pkg;

  localparam int DIME_VAL    = 10;
  localparam int QUARTER_VAL = 25;
  localparam int DOLLAR_VAL  = 100;

  // Hopper bit positions on hop_empty / hop_ack / hop_req.
  localparam logic [1:0] IDX_DIME    = 2'd0;
  localparam logic [1:0] IDX_QUARTER = 2'd1;
  localparam logic [1:0] IDX_DOLLAR  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_PULSE    = 3'd2,
    ST_WAIT_ACK = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } disp_state_t;

  // One-hot hopper drive pattern for a coin index.
  function automatic logic [2:0] coin_onehot(input logic [1:0] idx);
    coin_onehot = 3'b001 << idx;
  endfunction

endpackage

// File: rtl/change_dispenser_ctrl_if.sv
// Signal bundle between the vending FSM / hopper pins (master side) and
// the change dispenser controller (slave side).
//
// Handshake: start is a one-shot request that is accepted only on a clock
// edge where the controller is idle (busy=0); amount is captured on that
// same edge and start while busy is ignored. Each coin is requested by a
// single hop_req bit held for a fixed pulse width; the hopper answers with
// a one-cycle hop_ack on the same bit once the coin has left. done pulses
// for one cycle when the transaction ends, with dispensed/remainder final.
interface change_dispenser_ctrl_if #(
  parameter int AMT_W = 10
) ();
  logic             start;
  logic [AMT_W-1:0] amount;
  logic [2:0]       hop_empty;
  logic [2:0]       hop_ack;
  logic [2:0]       hop_req;
  logic             busy;
  logic             done;
  logic             error;
  logic [AMT_W-1:0] dispensed;
  logic [AMT_W-1:0] remainder;

  modport master (
    output start, amount, hop_empty, hop_ack,
    input  hop_req, busy, done, error, dispensed, remainder
  );

  modport slave (
    input  start, amount, hop_empty, hop_ack,
    output hop_req, busy, done, error, dispensed, remainder
  );
endinterface

// File: rtl/change_dispenser_ctrl_hop_timer.sv
// Loadable down-counter shared by the eject pulse width and the
// ack timeout. load wins over en; the count parks at zero.
module change_dispenser_ctrl_hop_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // Count register: reload on request, otherwise decrement toward zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Change dispenser controller: pays a change amount greedily from the
// dollar, quarter and dime hoppers, skipping empty ones, and reports
// whatever cannot be paid as a remainder. A hopper that never confirms
// its coin ends the payout with a sticky error.
module change_dispenser_ctrl
  import change_dispenser_ctrl_pkg::*;
#(
  parameter int AMT_W          = 10,
  parameter int DIME_CENTS     = DIME_VAL,
  parameter int QUARTER_CENTS  = QUARTER_VAL,
  parameter int DOLLAR_CENTS   = DOLLAR_VAL,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst,
  change_dispenser_ctrl_if.slave   bus,
  output disp_state_t              dbg_state
);

  localparam logic [AMT_W-1:0] DIME_V    = AMT_W'(DIME_CENTS);
  localparam logic [AMT_W-1:0] QUARTER_V = AMT_W'(QUARTER_CENTS);
  localparam logic [AMT_W-1:0] DOLLAR_V  = AMT_W'(DOLLAR_CENTS);

  // One timer covers both phases, so size it for the longer of the two.
  localparam int MAX_LD = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
  localparam int TW     = $clog2(MAX_LD + 1);
  // Loading N-1 gives exactly N cycles in the phase before zero is seen.
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LD   = TW'(TIMEOUT_CYCLES - 1);

  disp_state_t      state, state_nxt;
  logic [AMT_W-1:0] remaining;
  logic [AMT_W-1:0] dispensed_q;
  logic [AMT_W-1:0] remainder_q;
  logic             error_q;
  logic [2:0]       hop_req_q;
  logic [1:0]       coin_idx;

  logic             found;
  logic [1:0]       sel_idx;
  logic [AMT_W-1:0] cur_val;
  logic             ack_hit;

  logic             tmr_load;
  logic             tmr_en;
  logic [TW-1:0]    tmr_val;
  logic             tmr_zero;

  change_dispenser_ctrl_hop_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Greedy choice: largest coin that still fits and whose hopper has coins.
  always_comb begin
    found   = 1'b1;
    sel_idx = IDX_DIME;
    if ((remaining >= DOLLAR_V) && !bus.hop_empty[IDX_DOLLAR]) begin
      sel_idx = IDX_DOLLAR;
    end else if ((remaining >= QUARTER_V) && !bus.hop_empty[IDX_QUARTER]) begin
      sel_idx = IDX_QUARTER;
    end else if ((remaining >= DIME_V) && !bus.hop_empty[IDX_DIME]) begin
      sel_idx = IDX_DIME;
    end else begin
      found = 1'b0;
    end
  end

  // Value of the coin currently being ejected.
  always_comb begin
    case (coin_idx)
      IDX_DOLLAR:  cur_val = DOLLAR_V;
      IDX_QUARTER: cur_val = QUARTER_V;
      default:     cur_val = DIME_V;
    endcase
  end

  // Only the hopper we are waiting on can confirm a coin.
  assign ack_hit = bus.hop_ack[coin_idx];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and timer control.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_nxt = ST_SELECT;
      end
      ST_SELECT: begin
        if (found) begin
          state_nxt = ST_PULSE;
          tmr_load  = 1'b1;
          tmr_val   = PULSE_LD;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          state_nxt = ST_WAIT_ACK;
          tmr_load  = 1'b1;
          tmr_val   = TMO_LD;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // An ack on the final timeout cycle still counts as a paid coin.
        if (ack_hit) begin
          state_nxt = ST_SELECT;
        end else if (tmr_zero) begin
          state_nxt = ST_ERR;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Payout bookkeeping and the registered hopper drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining   <= '0;
      dispensed_q <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
      hop_req_q   <= 3'b000;
      coin_idx    <= IDX_DIME;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            remaining   <= bus.amount;
            dispensed_q <= '0;
            remainder_q <= '0;
            error_q     <= 1'b0;
          end
        end
        ST_SELECT: begin
          if (found) begin
            coin_idx  <= sel_idx;
            hop_req_q <= coin_onehot(sel_idx);
          end else begin
            remainder_q <= remaining;
          end
        end
        ST_PULSE: begin
          if (tmr_zero) hop_req_q <= 3'b000;
        end
        ST_WAIT_ACK: begin
          if (ack_hit) begin
            // cur_val <= remaining is guaranteed by the selection.
            remaining   <= remaining - cur_val;
            dispensed_q <= dispensed_q + cur_val;
          end else if (tmr_zero) begin
            remainder_q <= remaining;
            error_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hop_req   = hop_req_q;
  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE) || (state == ST_ERR);
  assign bus.error     = error_q;
  assign bus.dispensed = dispensed_q;
  assign bus.remainder = remainder_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: a timeline model of the payout checked
// against the DUT every cycle, plus literal coin sequences and totals for
// directed cases and greedy-derived expectations for random ones.
module tb_change_dispenser_ctrl;
  import change_dispenser_ctrl_pkg::*;

  localparam int AMT_W = 10;
  localparam int PULSE = 4;
  localparam int TMO   = 1000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  disp_state_t dbg_state;
  change_dispenser_ctrl_if #(.AMT_W(AMT_W)) bus();

  change_dispenser_ctrl #(
    .AMT_W(AMT_W), .DIME_CENTS(10), .QUARTER_CENTS(25), .DOLLAR_CENTS(100),
    .PULSE_CYCLES(PULSE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int coin_val(input int i);
    case (i)
      0:       return 10;
      1:       return 25;
      default: return 100;
    endcase
  endfunction

  // Largest affordable coin from a non-empty hopper, or -1.
  function automatic int pick(input int rem, input logic [2:0] emp);
    for (int i = 2; i >= 0; i--) begin
      if (!emp[i] && rem >= coin_val(i)) return i;
    end
    return -1;
  endfunction

  // ---------------- behavioural model (payout timeline) ----------------
  bit         m_busy, m_done, m_err;
  logic [2:0] m_req;
  int         m_disp, m_remd;

  task automatic m_clear();
    m_busy = 0; m_done = 0; m_err = 0; m_req = 3'b000; m_disp = 0; m_remd = 0;
  endtask

  task automatic m_step(output bit ab);
    @(posedge clk or posedge rst);
    ab = rst;
  endtask

  // Called right after the edge that accepted start.
  task automatic m_payout(input int amt);
    int rem;
    int c;
    bit ab;
    bit acked;
    rem = amt;
    m_busy = 1; m_disp = 0; m_remd = 0; m_err = 0; m_req = 3'b000; m_done = 0;
    forever begin
      // one selection cycle
      m_step(ab);
      if (ab) begin m_clear(); return; end
      c = pick(rem, bus.hop_empty);
      if (c < 0) begin
        m_remd = rem; m_done = 1;
        m_step(ab);
        if (ab) begin m_clear(); return; end
        m_done = 0; m_busy = 0;
        return;
      end
      // eject pulse of fixed width
      m_req = 3'b001 << c;
      for (int p = 0; p < PULSE; p++) begin
        m_step(ab);
        if (ab) begin m_clear(); return; end
      end
      m_req = 3'b000;
      // wait for this hopper's ack, bounded by the timeout
      acked = 0;
      for (int t = 0; t < TMO && !acked; t++) begin
        m_step(ab);
        if (ab) begin m_clear(); return; end
        if (bus.hop_ack[c]) begin
          acked = 1;
          rem    -= coin_val(c);
          m_disp += coin_val(c);
        end
      end
      if (!acked) begin
        m_remd = rem; m_err = 1; m_done = 1;
        m_step(ab);
        if (ab) begin m_clear(); return; end
        m_done = 0; m_busy = 0;
        return;
      end
    end
  endtask

  initial begin : model
    bit ab;
    m_clear();
    forever begin
      m_step(ab);
      if (ab) m_clear();
      else if (bus.start) m_payout(int'(bus.amount));
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy",       int'(bus.busy),      int'(m_busy));
    chk("done",       int'(bus.done),      int'(m_done));
    chk("hop_req",    int'(bus.hop_req),   int'(m_req));
    chk("error",      int'(bus.error),     int'(m_err));
    chk("dispensed",  int'(bus.dispensed), m_disp);
    chk("remainder",  int'(bus.remainder), m_remd);
    chk("req_onehot", int'($countones(bus.hop_req) <= 1), 1);
  end

  // ---------------- coin sequence monitor ----------------
  logic [2:0] prev_req = 3'b000;
  int         last_fall_cyc = 0;
  always @(negedge clk) begin
    if (bus.hop_req != 3'b000 && prev_req == 3'b000) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", int'(bus.hop_req), 0);
      else                   chk("coin_seq", int'(bus.hop_req), int'(exp_q.pop_front()));
    end
    if (bus.hop_req == 3'b000 && prev_req != 3'b000) last_fall_cyc = cyc;
    prev_req = bus.hop_req;
  end

  // ---------------- hopper responder ----------------
  bit         ack_on    = 1;
  bit         noise_on  = 0;
  int         ack_delay = 3;
  int         ack_cnt   = -1;
  logic [2:0] pend_bit  = 3'b000;
  always @(negedge clk) begin
    if (rst) begin
      bus.hop_ack = 3'b000; ack_cnt = -1; pend_bit = 3'b000;
    end else begin
      if (noise_on && $urandom_range(0, 9) == 0) bus.hop_ack = 3'($urandom_range(0, 7));
      else                                       bus.hop_ack = 3'b000;
      if (bus.hop_req != 3'b000) begin
        pend_bit = bus.hop_req; ack_cnt = ack_delay;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
      end else if (ack_cnt == 0) begin
        if (ack_on) bus.hop_ack = bus.hop_ack | pend_bit;
        ack_cnt = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic kick(input int amt);
    @(negedge clk);
    bus.amount = AMT_W'(amt);
    bus.start  = 1'b1;
  endtask

  // Waits for done; optionally pulses a bogus start while busy.
  task automatic wait_done(input int limit, input int poke_at, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      bus.start = 1'b0;
      if (bus.done) break;
      if (cycles == poke_at) begin
        bus.start  = 1'b1;
        bus.amount = AMT_W'(7);
      end
      if (cycles >= limit) begin
        chk("done_wait_expired", 0, 1);
        break;
      end
    end
  endtask

  task automatic run_txn(input string tag, input int amt, input int exp_disp,
                         input int exp_rem, input int exp_err, input int poke_at,
                         output int cycles);
    kick(amt);
    wait_done(4000, poke_at, cycles);
    chk({tag, "_disp"},       int'(bus.dispensed), exp_disp);
    chk({tag, "_rem"},        int'(bus.remainder), exp_rem);
    chk({tag, "_err"},        int'(bus.error),     exp_err);
    chk({tag, "_model_disp"}, m_disp,              exp_disp);
    chk({tag, "_coins_left"}, exp_q.size(),        0);
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic push_greedy(input int amt, input logic [2:0] emp,
                             output int disp, output int rem);
    int c;
    rem  = amt;
    disp = 0;
    c    = pick(rem, emp);
    while (c >= 0) begin
      exp_q.push_back(3'b001 << c);
      disp += coin_val(c);
      rem  -= coin_val(c);
      c     = pick(rem, emp);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cyc_n;
    int n;
    int amt;
    int ed;
    int er;
    logic [2:0] emp;

    bus.start = 1'b0; bus.amount = '0; bus.hop_empty = 3'b000;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  int'(bus.busy),      0);
    chk("rst_done",  int'(bus.done),      0);
    chk("rst_req",   int'(bus.hop_req),   0);
    chk("rst_error", int'(bus.error),     0);
    chk("rst_disp",  int'(bus.dispensed), 0);
    chk("rst_rem",   int'(bus.remainder), 0);
    chk("rst_state", int'(dbg_state),     int'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // 185, all full: dollar, quarter x3, dime
    exp_q = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b001};
    run_txn("a185", 185, 185, 0, 0, 0, cyc_n);

    // 65: quarter, quarter, dime, 5 left
    exp_q = '{3'b010, 3'b010, 3'b001};
    run_txn("a65", 65, 60, 5, 0, 0, cyc_n);

    // 120 with dollar hopper empty: four quarters, two dimes
    bus.hop_empty = 3'b100;
    exp_q = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001};
    run_txn("a120", 120, 120, 0, 0, 0, cyc_n);
    bus.hop_empty = 3'b000;

    // 50 with the first quarter never acked: timeout
    ack_on = 0;
    exp_q = '{3'b010};
    run_txn("tmo", 50, 0, 50, 1, 0, cyc_n);
    chk("tmo_latency", (cyc - 1) - last_fall_cyc, TMO);
    ack_on = 1;
    exp_q = '{3'b001};
    run_txn("after_tmo", 10, 10, 0, 0, 0, cyc_n);

    // zero amount: done two cycles after start, no pulses
    run_txn("zero", 0, 0, 0, 0, 0, cyc_n);
    chk("zero_latency", cyc_n, 2);

    // start pulsed while busy is ignored
    exp_q = '{3'b100, 3'b010, 3'b010, 3'b010, 3'b001};
    run_txn("poke", 185, 185, 0, 0, 10, cyc_n);

    // reset during the dollar pulse
    exp_q = '{3'b100};
    kick(185);
    n = 0;
    while (bus.hop_req != 3'b100 && n < 50) begin
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    chk("rst_saw_dollar", int'(bus.hop_req), 4);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_req",  int'(bus.hop_req),   0);
    chk("rst_async_busy", int'(bus.busy),      0);
    chk("rst_async_disp", int'(bus.dispensed), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_q = '{3'b010, 3'b001};
    run_txn("post_rst", 35, 35, 0, 0, 0, cyc_n);

    // randomized payouts with stray acks
    noise_on = 1;
    for (int k = 0; k < 16; k++) begin
      amt       = $urandom_range(0, 400);
      emp       = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      ack_delay = $urandom_range(0, 6);
      bus.hop_empty = emp;
      push_greedy(amt, emp, ed, er);
      run_txn("rand", amt, ed, er, 0, 0, cyc_n);
    end
    noise_on = 0;
    bus.hop_empty = 3'b000;

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
